fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the combinational, byte-addressed, big-endian instruction memory on behalf of decode.
//  Owns the fetch PC and issues one 32b fetch per cycle into a small in-order buffer.
//  Presents {pc, instr} to decode over a valid/ready handshake.
//  Accepts redirects (branch, CBZ, exception) from execute; a redirect flushes everything already fetched.
// PARAMETERS
//  RESET_PC    64'h0  fetch PC loaded on reset
//  IMEM_BYTES  64     instruction memory size in bytes; legal fetch PCs are 0..IMEM_BYTES-4
//  FIFO_DEPTH  2      fetch buffer entries, >=2, power of 2
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   synchronous, active-high
//  imem_addr        out  64  PC driven to instruction memory; memory returns data in the same cycle
//  imem_rdata       in   32  instruction for imem_addr, already assembled big-endian
//  redirect_valid   in   1   1-cycle pulse: discard fetched work and restart at redirect_target
//  redirect_target  in   64  new fetch PC
//  out_valid        out  1   buffer head is valid
//  out_ready        in   1   decode accepts head when out_valid && out_ready
//  out_pc           out  64  PC of head instruction
//  out_instr        out  32  head instruction
//  halted           out  1   fetch PC is out of range; fetching stopped
//  misalign_err     out  1   1-cycle pulse: redirect_target[1:0] != 0
// BEHAVIOUR
//  Reset (synchronous, wins over all inputs): buffer empty, fetch_pc=RESET_PC, state=RUN.
//    Output values in reset: out_valid=0, out_pc=0, out_instr=0, halted=0, misalign_err=0, imem_addr=RESET_PC.
//  imem_addr = fetch_pc at all times (combinational from the register).
//  States:
//    RUN:  fetch_pc <= IMEM_BYTES-4.
//    HALT: fetch_pc > IMEM_BYTES-4. halted=1. No pushes occur.
//  Push condition: state==RUN && !redirect_valid && (count<FIFO_DEPTH || pop).
//    On push, write {fetch_pc, imem_rdata} and set fetch_pc <= fetch_pc+4.
//    The 64b add wraps modulo 2^64; the range check alone decides RUN/HALT.
//  Pop condition: out_valid && out_ready && !redirect_valid.
//    Simultaneous push and pop on a full buffer is legal; count is unchanged.
//  Latency:
//    A push in cycle N gives out_valid in cycle N+1 (registered buffer).
//    The first instruction after reset release is visible 1 cycle later.
//  Redirect in cycle N:
//    Buffer flushed, and any pop in cycle N is ignored (the head is dropped, not consumed).
//    fetch_pc <= {redirect_target[63:2], 2'b00}. State is re-evaluated against the new PC.
//    The first redirected instruction appears with out_valid in cycle N+2.
//    misalign_err pulses in cycle N+1 when redirect_target[1:0] != 0.
//  HALT exits only through a redirect to an in-range PC, or through reset.
//    Entries already buffered still drain normally while halted.
//  Back-pressure: while out_ready=0 the head is stable (pc, instr, valid all unchanged).
//    Entries are never dropped or reordered except by redirect.
//  Handshake rule: out_valid, once asserted, stays asserted until pop, redirect or reset.
// CONFIGURATION
//  FETCH_BRANCH_PREDECODE_EN defined:
//    On push of an instruction with instr[31:26]==6'b000101 (unconditional B), the next fetch_pc is
//      pc + ({{36{imm26[25]}}, imm26, 2'b00}), where imm26 = instr[25:0], instead of pc+4.
//    The B instruction itself is still pushed to decode.
//    An external redirect in the same cycle takes priority over the predecoded target.
//  FETCH_BRANCH_PREDECODE_EN undefined: fetch is purely sequential; all branches resolve via redirect.
// TESTING
//  1. Reset, out_ready=1 -> cycle 1 gives out_pc=0x0, out_instr=0xF8400182; cycle 2 gives out_pc=0x4, out_instr=0xF84001A3.
//  2. out_ready=0 for 5 cycles -> the buffer holds 2 entries, imem_addr is frozen at 0x8, and the head is stable.
//     Then release -> PCs 0x0, 0x4, 0x8 arrive in order with no gaps or drops.
//  3. redirect_valid with target 0x1C while the buffer is full and out_ready=1 ->
//     buffered entries vanish, and 2 cycles later out_pc=0x1C, out_instr=0xB40001A6.
//  4. Sequential run to 0x3C (macro off) -> out_pc=0x3C, out_instr=0x14000014 is delivered,
//     then halted=1 and out_valid=0 after the drain. A redirect to 0x0 restarts fetch.
//  5. Redirect with target 0x2E -> misalign_err pulses once, then out_pc=0x2C, out_instr=0xF80010E5.
//  6. Macro on: fetch 0x38 (0x14000014) -> next fetch_pc=0x88 and halted=1.
//     Separately, reset asserted mid-stream -> next cycle all outputs are at their reset values and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, reads one 32b instruction per cycle from a
// combinational instruction memory and queues {pc, instr} for decode behind a
// valid/ready handshake. Redirects from execute flush all fetched work.
// Optional build macro: FETCH_BRANCH_PREDECODE_EN follows unconditional B
// instructions at fetch time instead of fetching sequentially.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 64,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted,
    output logic        misalign_err
);

    localparam int          PtrW   = $clog2(FIFO_DEPTH);
    localparam int          CntW   = PtrW + 1;
    localparam logic [63:0] LastPc = 64'(IMEM_BYTES - 4);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetchState_e;

    fetchState_e     state_q, state_d;
    logic [63:0]     fetchPc_q, fetchPc_d;
    logic [PtrW-1:0] rdPtr_q, rdPtr_d;
    logic [PtrW-1:0] wrPtr_q, wrPtr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            misalign_q, misalign_d;

    logic [63:0]     pcMem_q    [FIFO_DEPTH];
    logic [31:0]     instrMem_q [FIFO_DEPTH];

    logic            bufValid;
    logic            popEn;
    logic            pushEn;
    logic [63:0]     pushNextPc;

    assign bufValid = (count_q != '0);
    // A redirect drops the head instead of handing it to decode.
    assign popEn    = bufValid && out_ready && !redirect_valid;
    // A full buffer can still accept a push when the head leaves this cycle.
    assign pushEn   = (state_q == RUN) && !redirect_valid &&
                      ((count_q < CntW'(FIFO_DEPTH)) || popEn);

`ifdef FETCH_BRANCH_PREDECODE_EN
    logic        isUncondBranch;
    logic [63:0] branchOffset;

    assign isUncondBranch = (imem_rdata[31:26] == 6'b000101);
    assign branchOffset   = {{36{imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
    assign pushNextPc     = isUncondBranch ? (fetchPc_q + branchOffset)
                                           : (fetchPc_q + 64'd4);
`else
    assign pushNextPc     = fetchPc_q + 64'd4;
`endif

    assign imem_addr    = fetchPc_q;
    assign out_valid    = bufValid;
    assign out_pc       = bufValid ? pcMem_q[rdPtr_q] : 64'h0;
    assign out_instr    = bufValid ? instrMem_q[rdPtr_q] : 32'h0;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;

    // Next-state logic: redirect flushes and reloads the PC, otherwise push/pop update the buffer.
    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        misalign_d = redirect_valid && (redirect_target[1:0] != 2'b00);

        if (redirect_valid) begin
            fetchPc_d = {redirect_target[63:2], 2'b00};
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            state_d   = (fetchPc_d > LastPc) ? HALT : RUN;
        end else begin
            if (pushEn) begin
                fetchPc_d = pushNextPc;
                wrPtr_d   = wrPtr_q + PtrW'(1);
                state_d   = (fetchPc_d > LastPc) ? HALT : RUN;
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PtrW'(1);
            end
            unique case ({pushEn, popEn})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetchPc_q  <= RESET_PC;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Buffer storage needs no reset; outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (!reset && pushEn) begin
            pcMem_q[wrPtr_q]    <= fetchPc_q;
            instrMem_q[wrPtr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic, all compared with a queue-based reference model.
// Honors FETCH_BRANCH_PREDECODE_EN the same way the design does.
module tb_fetch_sequencer;

    localparam int          FifoDepth = 2;
    localparam logic [63:0] ResetPc   = 64'h0;
    localparam logic [63:0] LastPc    = 64'd60;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];

    fetch_sequencer #(
        .RESET_PC   (ResetPc),
        .IMEM_BYTES (64),
        .FIFO_DEPTH (FifoDepth)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .halted          (halted),
        .misalign_err    (misalign_err)
    );

    // Combinational instruction memory; out-of-range addresses read as zero.
    assign imem_rdata = (imem_addr <= LastPc) ? mem[imem_addr[5:2]] : 32'h0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of test expected end of test");
        $fatal(1, "[TB] time limit reached");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mQ[$];
    logic [63:0] mPc  = ResetPc;
    logic        mMis = 1'b0;

    function automatic logic [63:0] nextOffset(input logic [31:0] ir);
`ifdef FETCH_BRANCH_PREDECODE_EN
        if (ir[31:26] == 6'b000101)
            return 64'(longint'($signed(ir[25:0])) * 4);
`endif
        return 64'd4 + 64'(ir & 32'h0);
    endfunction

    function automatic void modelStep(input logic rst, input logic rdy,
                                      input logic rv, input logic [63:0] tgt);
        entry_t e;
        logic   popOk;
        logic   pushOk;
        if (rst) begin
            mQ.delete();
            mPc  = ResetPc;
            mMis = 1'b0;
            return;
        end
        mMis = rv && (tgt[1:0] != 2'b00);
        if (rv) begin
            mQ.delete();
            mPc = tgt & ~64'd3;
            return;
        end
        popOk  = (mQ.size() > 0) && rdy;
        pushOk = (mPc <= LastPc) && ((mQ.size() < FifoDepth) || popOk);
        if (popOk) void'(mQ.pop_front());
        if (pushOk) begin
            e.pc    = mPc;
            e.instr = mem[mPc[5:2]];
            mQ.push_back(e);
            mPc = mPc + nextOffset(e.instr);
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eValid, input logic [63:0] ePc,
                               input logic [31:0] eInstr, input logic [63:0] eAddr,
                               input logic eHalt, input logic eMis);
        checkVal({tag, ".out_valid"}, 64'(out_valid), 64'(eValid));
        checkVal({tag, ".out_pc"}, out_pc, ePc);
        checkVal({tag, ".out_instr"}, 64'(out_instr), 64'(eInstr));
        checkVal({tag, ".imem_addr"}, imem_addr, eAddr);
        checkVal({tag, ".halted"}, 64'(halted), 64'(eHalt));
        checkVal({tag, ".misalign_err"}, 64'(misalign_err), 64'(eMis));
    endtask

    task automatic checkModel(input string tag);
        logic mValid;
        mValid = (mQ.size() > 0);
        checkOutput(tag, mValid, mValid ? mQ[0].pc : 64'h0, mValid ? mQ[0].instr : 32'h0,
                    mPc, (mPc > LastPc), mMis);
    endtask

    // Drive one cycle of inputs, advance the model and the DUT, then compare with the model.
    task automatic applyStimulus(input logic rst, input logic rdy,
                                 input logic rv, input logic [63:0] tgt);
        reset           = rst;
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        modelStep(rst, rdy, rv, tgt);
        @(posedge clk);
        #1;
        checkModel("model");
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [63:0] tgt;
        logic        eValid;
        logic [63:0] ePc;
        logic [31:0] eInstr;
        logic [63:0] eAddr;
    } vec_t;

    function automatic vec_t mkVec(input logic rst, input logic rdy, input logic rv,
                                   input logic [63:0] tgt, input logic eValid,
                                   input logic [63:0] ePc, input logic [31:0] eInstr,
                                   input logic [63:0] eAddr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
        v.eValid = eValid; v.ePc = ePc; v.eInstr = eInstr; v.eAddr = eAddr;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hD503_2000 + 32'(i);
        mem[0]  = 32'hF840_0182;
        mem[1]  = 32'hF840_01A3;
        mem[7]  = 32'hB400_01A6;
        mem[11] = 32'hF800_10E5;
        mem[14] = 32'h1400_0014;
        mem[15] = 32'h1400_0014;

        // reset, then free flow
        vecs[0]  = mkVec(1, 1, 0, 0,     0, 64'h0,  32'h0,          64'h0);
        vecs[1]  = mkVec(0, 1, 0, 0,     1, 64'h0,  32'hF840_0182,  64'h4);
        vecs[2]  = mkVec(0, 1, 0, 0,     1, 64'h4,  32'hF840_01A3,  64'h8);
        // back-pressure from reset for five cycles
        vecs[3]  = mkVec(1, 0, 0, 0,     0, 64'h0,  32'h0,          64'h0);
        vecs[4]  = mkVec(0, 0, 0, 0,     1, 64'h0,  32'hF840_0182,  64'h4);
        vecs[5]  = mkVec(0, 0, 0, 0,     1, 64'h0,  32'hF840_0182,  64'h8);
        vecs[6]  = mkVec(0, 0, 0, 0,     1, 64'h0,  32'hF840_0182,  64'h8);
        vecs[7]  = mkVec(0, 0, 0, 0,     1, 64'h0,  32'hF840_0182,  64'h8);
        vecs[8]  = mkVec(0, 0, 0, 0,     1, 64'h0,  32'hF840_0182,  64'h8);
        vecs[9]  = mkVec(0, 1, 0, 0,     1, 64'h4,  32'hF840_01A3,  64'hC);
        vecs[10] = mkVec(0, 1, 0, 0,     1, 64'h8,  mem[2],         64'h10);
        vecs[11] = mkVec(0, 1, 0, 0,     1, 64'hC,  mem[3],         64'h14);
        // redirect with a full buffer
        vecs[12] = mkVec(0, 1, 1, 64'h1C, 0, 64'h0, 32'h0,          64'h1C);
        vecs[13] = mkVec(0, 1, 0, 0,     1, 64'h1C, 32'hB400_01A6,  64'h20);

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].tgt);
            checkOutput($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].ePc,
                        vecs[i].eInstr, vecs[i].eAddr, 1'b0, 1'b0);
        end

`ifndef FETCH_BRANCH_PREDECODE_EN
        // Sequential run off the end of memory, drain, then restart.
        begin
            bit seen;
            $display("[TB] run to end of memory");
            seen = 0;
            applyStimulus(0, 1, 1, 64'h30);
            for (int i = 0; i < 20 && !seen; i++) begin
                applyStimulus(0, 1, 0, 0);
                if (out_valid && out_pc == 64'h3C) seen = 1;
            end
            checkVal("reach3C", 64'(seen), 64'd1);
            checkVal("instr3C", 64'(out_instr), 64'h1400_0014);
            applyStimulus(0, 1, 0, 0);
            checkVal("drain.halted", 64'(halted), 64'd1);
            checkVal("drain.valid", 64'(out_valid), 64'd0);
            for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
            checkVal("haltHold.halted", 64'(halted), 64'd1);
            checkVal("haltHold.addr", imem_addr, 64'h40);
            applyStimulus(0, 1, 1, 64'h0);
            checkVal("restart.halted", 64'(halted), 64'd0);
            applyStimulus(0, 1, 0, 0);
            checkOutput("restart", 1'b1, 64'h0, 32'hF840_0182, 64'h4, 1'b0, 1'b0);
        end
`else
        // Predecoded B at 0x38 jumps fetch out of range.
        $display("[TB] predecoded branch");
        applyStimulus(0, 1, 1, 64'h38);
        applyStimulus(0, 1, 0, 0);
        checkOutput("predecode", 1'b1, 64'h38, 32'h1400_0014, 64'h88, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkVal("predecode.drain", 64'(out_valid), 64'd0);
`endif

        // Misaligned redirect target.
        $display("[TB] misaligned redirect");
        applyStimulus(0, 1, 1, 64'h2E);
        checkVal("mis.pulse", 64'(misalign_err), 64'd1);
        checkVal("mis.addr", imem_addr, 64'h2C);
        applyStimulus(0, 1, 0, 0);
        checkOutput("mis.first", 1'b1, 64'h2C, 32'hF800_10E5, 64'h30, 1'b0, 1'b0);

        // Randomized traffic against the model.
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic        rst, rdy, rv;
            logic [63:0] tgt;
            int          sel;
            rst = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      tgt = 64'($urandom_range(0, 63));
            else if (sel < 9) tgt = 64'h40 + 64'($urandom_range(0, 31));
            else              tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            applyStimulus(rst, rdy, rv, tgt);
        end

        // Reset in the middle of a back-pressured stream.
        $display("[TB] mid-stream reset");
        applyStimulus(0, 1, 1, 64'h10);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 64'h2E);
        checkOutput("midReset", 1'b0, 64'h0, 32'h0, ResetPc, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("afterReset", 1'b1, 64'h0, 32'hF840_0182, 64'h4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
